// File: rtl/nanorisc_program_loader_pkg.sv
// Shared NanoRisc loader definitions: state encodings, width defaults and the
// NANORISC_LOADER_CHECKSUM_EN feature switch.
package nanorisc_program_loader_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

`ifdef NANORISC_LOADER_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;
`else
  localparam bit CHECKSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/nanorisc_program_loader_checksum.sv
// Running 8-bit sum of the payload; o_zero reports whether sum + i_data wraps to 0.
// Only built when NANORISC_LOADER_CHECKSUM_EN is defined.
`ifdef NANORISC_LOADER_CHECKSUM_EN
module loader_checksum #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_add,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_total;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign w_total = r_sum + i_data;
  assign o_zero  = (w_total == '0);

endmodule
`endif

// File: rtl/nanorisc_program_loader.sv
// Byte-stream program loader: LEN, N payload bytes (+ checksum when
// NANORISC_LOADER_CHECKSUM_EN is defined) into instruction memory, holding the CPU until done.
module nanorisc_program_loader
  import nanorisc_program_loader_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_write_enable,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [DATA_WIDTH-1:0] imem_write_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH-1:0] bytes_loaded
);

  state_e                r_state;
  state_e                w_next;
  logic [DATA_WIDTH-1:0] r_len;
  logic [DATA_WIDTH-1:0] r_index;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_sum_zero;

  assign rx_ready = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CHECK);
  assign w_xfer   = rx_valid && rx_ready;
  assign w_last   = (r_index == r_len - 1'b1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next takes its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_next = ST_LEN;
      ST_LEN: begin
        if (w_xfer) begin
          if (rx_data != '0)   w_next = ST_DATA;
          else if (CHECKSUM_EN) w_next = ST_CHECK;
          else                  w_next = ST_DONE;
        end
      end
      ST_DATA: begin
        if (w_xfer && w_last) begin
          if (CHECKSUM_EN) w_next = ST_CHECK;
          else             w_next = ST_DONE;
        end
      end
      ST_CHECK: if (w_xfer) w_next = w_sum_zero ? ST_DONE : ST_ERROR;
      ST_DONE,
      ST_ERROR: if (start) w_next = ST_LEN;
      default: w_next = ST_IDLE;
    endcase
  end

  // Write strobe is a single registered pulse per accepted payload byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_len   <= '0;
      r_index <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_state == ST_LEN && w_xfer) begin
        r_len   <= rx_data;
        r_index <= '0;
        r_count <= '0;
      end
      if (r_state == ST_DATA && w_xfer) begin
        r_we    <= 1'b1;
        r_addr  <= BASE_ADDRESS + ADDR_WIDTH'(r_index);
        r_wdata <= rx_data;
        r_index <= r_index + 1'b1;
        r_count <= r_count + 1'b1;
      end
    end
  end

`ifdef NANORISC_LOADER_CHECKSUM_EN
  loader_checksum #(
    .WIDTH(DATA_WIDTH)
  ) u_checksum (
    .clock  (clock),
    .reset  (reset),
    .i_clear(r_state == ST_LEN && w_xfer),
    .i_add  (r_state == ST_DATA && w_xfer),
    .i_data (rx_data),
    .o_zero (w_sum_zero)
  );
  assign load_error = (r_state == ST_ERROR);
`else
  assign w_sum_zero = 1'b0;
  assign load_error = 1'b0;
`endif

  assign imem_write_enable = r_we;
  assign imem_address      = r_addr;
  assign imem_write_data   = r_wdata;
  assign bytes_loaded      = r_count;
  assign load_done         = (r_state == ST_DONE);
  assign cpu_hold          = (r_state != ST_DONE);

endmodule

// File: tb/tb_nanorisc_program_loader.sv
// Bench for nanorisc_program_loader: two instances (base 0x00 and 0xFE) share one stream
// and are checked every cycle against a transaction-level model, plus literal pins.
module tb_nanorisc_program_loader;

  typedef enum {P_IDLE, P_BUSY, P_DONE, P_ERR} phase_e;
  typedef enum {S_LEN, S_DATA, S_CHK} stage_e;
  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  typedef logic [7:0] bq_t[$];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic       rdy_a, we_a, hold_a, done_a, err_a;
  logic [7:0] addr_a, wd_a, bl_a;
  logic       rdy_b, we_b, hold_b, done_b, err_b;
  logic [7:0] addr_b, wd_b, bl_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state
  bit     model_on = 1'b0;
  phase_e phase = P_IDLE;
  stage_e stage = S_LEN;
  int     exp_n, exp_k, exp_sum, exp_bl;
  int     exp_we_cyc = -1;
  int     exp_wk;
  logic [7:0] exp_wd;
  wr_t    log_a[$];
  wr_t    log_b[$];

  nanorisc_program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDRESS(8'h00)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy_a), .imem_write_enable(we_a), .imem_address(addr_a),
    .imem_write_data(wd_a), .cpu_hold(hold_a), .load_done(done_a),
    .load_error(err_a), .bytes_loaded(bl_a)
  );

  nanorisc_program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDRESS(8'hFE)) dut_wrap (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy_b), .imem_write_enable(we_b), .imem_address(addr_b),
    .imem_write_data(wd_b), .cpu_hold(hold_b), .load_done(done_b),
    .load_error(err_b), .bytes_loaded(bl_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clock) begin
    bit ew;
    if (model_on) begin
      ew = (exp_we_cyc == cyc);
      check("rx_ready_a", rdy_a, phase == P_BUSY);
      check("rx_ready_b", rdy_b, phase == P_BUSY);
      check("load_done_a", done_a, phase == P_DONE);
      check("load_done_b", done_b, phase == P_DONE);
      check("load_error_a", err_a, phase == P_ERR);
      check("load_error_b", err_b, phase == P_ERR);
      check("cpu_hold_a", hold_a, phase != P_DONE);
      check("cpu_hold_b", hold_b, phase != P_DONE);
      check("we_a", we_a, ew);
      check("we_b", we_b, ew);
      check("bytes_loaded_a", bl_a, exp_bl % 256);
      check("bytes_loaded_b", bl_b, exp_bl % 256);
      if (ew && we_a) begin
        check("addr_a", addr_a, exp_wk % 256);
        check("data_a", wd_a, exp_wd);
      end
      if (ew && we_b) begin
        check("addr_b", addr_b, (8'hFE + exp_wk) % 256);
        check("data_b", wd_b, exp_wd);
      end
      if (we_a) log_a.push_back('{addr_a, wd_a});
      if (we_b) log_b.push_back('{addr_b, wd_b});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic finish_payload();
`ifdef NANORISC_LOADER_CHECKSUM_EN
    stage = S_CHK;
`else
    phase = P_DONE;
`endif
  endtask

  task automatic model_accept(input logic [7:0] b);
    case (stage)
      S_LEN: begin
        exp_n = b; exp_k = 0; exp_sum = 0; exp_bl = 0;
        if (b == 0) finish_payload();
        else        stage = S_DATA;
      end
      S_DATA: begin
        exp_we_cyc = cyc; exp_wk = exp_k; exp_wd = b;
        exp_bl++; exp_k++; exp_sum += b;
        if (exp_k == exp_n) finish_payload();
      end
      default: phase = ((exp_sum + b) % 256 == 0) ? P_DONE : P_ERR;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0;
    tick();
    phase = P_IDLE; stage = S_LEN; exp_bl = 0; exp_we_cyc = -1;
    model_on = 1'b1;
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (phase != P_BUSY) begin
      phase = P_BUSY;
      stage = S_LEN;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy;
    bit accepted = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int w = 0; w < 50; w++) begin
      @(negedge clock);
      rdy = rdy_a;
      tick();
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    rx_valid = 1'b0;
    check("xfer_accepted", accepted, 1'b1);
    if (accepted) model_accept(b);
    repeat (gap) tick();
  endtask

  task automatic run_load(input bq_t pl, input logic [7:0] csum, input int gap);
    pulse_start();
    send_byte(8'(pl.size()), gap);
    foreach (pl[i]) send_byte(pl[i], gap);
`ifdef NANORISC_LOADER_CHECKSUM_EN
    send_byte(csum, gap);
`else
    if (csum === 8'hxx) $display("unused checksum");
`endif
    tick();
  endtask

  initial begin
    bq_t p3;
    p3 = '{8'h11, 8'h22, 8'h33};

    // Reset values
    do_reset();
    @(negedge clock);
    check("rst_ready", rdy_a, 0);
    check("rst_we", we_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_wdata", wd_a, 0);
    check("rst_hold", hold_a, 1);
    check("rst_done", done_a, 0);
    check("rst_error", err_a, 0);
    check("rst_bl", bl_a, 0);
    tick();

    // Good load 03 11 22 33 / 9A
    log_a.delete(); log_b.delete();
    run_load(p3, 8'h9A, 0);
    check("t1_nwr", log_a.size(), 3);
    check("t1_a0", log_a[0].a, 8'h00); check("t1_d0", log_a[0].d, 8'h11);
    check("t1_a1", log_a[1].a, 8'h01); check("t1_d1", log_a[1].d, 8'h22);
    check("t1_a2", log_a[2].a, 8'h02); check("t1_d2", log_a[2].d, 8'h33);
    check("t1_bl", bl_a, 3);
    check("t1_done", done_a, 1);
    check("t1_hold", hold_a, 0);
    check("t1_err", err_a, 0);

    // Same payload with checksum 00, then a good reload
    log_a.delete(); log_b.delete();
    run_load(p3, 8'h00, 0);
    check("t2_nwr", log_a.size(), 3);
    check("t2_d2", log_a[2].d, 8'h33);
`ifdef NANORISC_LOADER_CHECKSUM_EN
    check("t2_err", err_a, 1);
    check("t2_hold", hold_a, 1);
    check("t2_done", done_a, 0);
`endif
    run_load(p3, 8'h9A, 0);
    check("t2_reload_done", done_a, 1);

    // Gapped 4-byte stream, 3 idle cycles between bytes
    log_a.delete(); log_b.delete();
    run_load('{8'h01, 8'h02, 8'h03, 8'h04}, 8'hF6, 3);
    check("t3_nwr", log_a.size(), 4);
    check("t3_d3", log_a[3].d, 8'h04);
    check("t3_done", done_a, 1);

    // Address wrap on the 0xFE-based instance
    log_a.delete(); log_b.delete();
    run_load('{8'hA0, 8'hA1, 8'hA2, 8'hA3}, 8'h7A, 0);
    check("t4_nwr", log_b.size(), 4);
    check("t4_a0", log_b[0].a, 8'hFE);
    check("t4_a1", log_b[1].a, 8'hFF);
    check("t4_a2", log_b[2].a, 8'h00);
    check("t4_a3", log_b[3].a, 8'h01);
    check("t4_done", done_b, 1);

    // Zero length
    log_a.delete(); log_b.delete();
    pulse_start();
    send_byte(8'h00, 0);
`ifndef NANORISC_LOADER_CHECKSUM_EN
    check("t5_done_next", done_a, 1);
`else
    send_byte(8'h00, 0);
`endif
    tick();
    check("t5_nwr", log_a.size(), 0);
    check("t5_done", done_a, 1);

    // Ignored start during DATA, then reset after the 2nd payload byte
    log_a.delete(); log_b.delete();
    pulse_start();
    send_byte(8'h05, 0);
    send_byte(8'h55, 0);
    pulse_start();
    send_byte(8'h66, 0);
    do_reset();
    @(negedge clock);
    check("t6_ready", rdy_a, 0);
    check("t6_hold", hold_a, 1);
    check("t6_bl", bl_a, 0);
    check("t6_done", done_a, 0);
    check("t6_nwr", log_a.size(), 2);
    check("t6_d1", log_a[1].d, 8'h66);
    tick();

    run_load(p3, 8'h9A, 1);
    check("t7_done", done_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
